// File: rtl/add_slice_seq.sv
// add_slice_seq: multi-cycle $add that ripples its carry one SLICE_WIDTH chunk per clock.
// Define ADD_SLICE_COUT_EN to add the registered carry-out port co.
module add_slice_seq #(
   parameter int A_SIGNED    = 0,
   parameter int B_SIGNED    = 0,
   parameter int A_WIDTH     = 8,
   parameter int B_WIDTH     = 8,
   parameter int Y_WIDTH     = 9,
   parameter int SLICE_WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_WIDTH-1:0] a,
   input  logic [B_WIDTH-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [Y_WIDTH-1:0] y
`ifdef ADD_SLICE_COUT_EN
   ,
   output logic               co
`endif
);
   localparam int NSLICE = (Y_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
   localparam int PW     = NSLICE * SLICE_WIDTH;
   localparam int LW     = Y_WIDTH - (NSLICE - 1) * SLICE_WIDTH;
   localparam int IW     = NSLICE > 1 ? $clog2(NSLICE) : 1;
   localparam bit SGN    = (A_SIGNED != 0) && (B_SIGNED != 0);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t               r_state;
   logic [PW-1:0]        r_a, r_b;
   logic [IW-1:0]        r_idx;
   logic                 r_c, r_in_ready, r_out_valid;
   logic [Y_WIDTH-1:0]   r_y;
   logic [Y_WIDTH-1:0]   w_ax, w_bx;
   logic [SLICE_WIDTH-1:0] w_sa, w_sb;
   logic [SLICE_WIDTH:0] w_sum;
   logic                 w_last;
`ifdef ADD_SLICE_COUT_EN
   logic                 r_co;
   assign co = r_co;
`endif
   assign w_ax   = SGN ? Y_WIDTH'($signed(a)) : Y_WIDTH'(a);
   assign w_bx   = SGN ? Y_WIDTH'($signed(b)) : Y_WIDTH'(b);
   assign w_sa   = r_a[int'(r_idx) * SLICE_WIDTH +: SLICE_WIDTH];
   assign w_sb   = r_b[int'(r_idx) * SLICE_WIDTH +: SLICE_WIDTH];
   assign w_sum  = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE_WIDTH{1'b0}}, r_c};
   assign w_last = r_idx == IW'(NSLICE - 1);
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign y         = r_y;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_idx       <= '0;
         r_c         <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_y         <= '0;
`ifdef ADD_SLICE_COUT_EN
         r_co        <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_a        <= PW'(w_ax);
               r_b        <= PW'(w_bx);
               r_c        <= 1'b0;
               r_idx      <= '0;
               r_in_ready <= 1'b0;
               r_state    <= RUN;
            end
            RUN: begin
               // pad bits above Y_WIDTH-1 in the last slice are never written
               for (int i = 0; i < Y_WIDTH; i++)
                  if (r_idx == IW'(i / SLICE_WIDTH)) r_y[i] <= w_sum[i % SLICE_WIDTH];
               r_c <= w_sum[SLICE_WIDTH];
               if (w_last) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
`ifdef ADD_SLICE_COUT_EN
                  r_co        <= w_sum[LW];
`endif
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/add_slice_seq.md
Name: add_slice_seq

Overview:
- Multi-cycle, bit-serialised-by-slice implementation of a Yosys-style `$add` (Y = A + B).
- Sits directly downstream of the add width-reduction stage. It consumes an adder whose Y_WIDTH is already minimised, then splits the carry chain into SLICE_WIDTH-bit chunks, one chunk per clock.
- Trades latency for a short carry path; operands and result move over valid/ready handshakes.

Parameters:
- A_SIGNED, 0, A operand signedness (same semantics as `$add`)
- B_SIGNED, 0, B operand signedness
- A_WIDTH, 8, width of A
- B_WIDTH, 8, width of B
- Y_WIDTH, 9, result width
- SLICE_WIDTH, 4, carry-chain bits computed per cycle; must be >= 1
- Derived: NSLICE = ceil(Y_WIDTH/SLICE_WIDTH)

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  A_WIDTH  operand A
- b  in  B_WIDTH  operand B
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- y  out  Y_WIDTH  registered sum
- co  out  1  carry out of bit Y_WIDTH-1 (only when ADD_SLICE_COUT_EN defined)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, co=0, slice index=0, carry=0.
- Operand extension: both operands are extended to Y_WIDTH at capture.
  - Sign-extend only when A_SIGNED=1 and B_SIGNED=1; otherwise zero-extend both.
  - Operands wider than Y_WIDTH are truncated to Y_WIDTH.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture the extended operands, clear carry, set index=0, go to RUN.
  - RUN: in_ready=0, out_valid=0.
    - Each cycle computes slice[index] = a_slice + b_slice + carry, writes it into y bits, and registers the slice carry-out.
    - At index==NSLICE-1, go to DONE; otherwise index+1.
  - DONE: out_valid=1, y stable. On out_ready go to IDLE; otherwise hold indefinitely.
- Latency: with the input handshake in cycle T, out_valid=1 first in cycle T+NSLICE+1. The earliest next in_ready is T+NSLICE+2 (out_ready already high at T+NSLICE+1).
- Last slice: when Y_WIDTH is not a multiple of SLICE_WIDTH, the last slice has width Y_WIDTH-(NSLICE-1)*SLICE_WIDTH.
  - Its upper pad bits are never written to y.
  - co is the carry out of bit Y_WIDTH-1, not of the pad.
- SLICE_WIDTH >= Y_WIDTH: NSLICE=1, and latency becomes 2 cycles to out_valid.
- Wrap-around: the result is modulo 2^Y_WIDTH, the same as `$add`. Overflow is not flagged other than through co.
- Input backpressure: in_valid outside IDLE is ignored, and a/b are not sampled.
- y during RUN: y keeps the previous result until overwritten slice by slice. Only the value under out_valid is defined.
- Reset mid-operation: reset_n low at any point aborts the operation immediately (asynchronously). All registers return to their reset values, and the partial result is discarded.

Optional Feature:
- Macro: ADD_SLICE_COUT_EN
- Defined: port co exists. co is registered with the final slice and is valid with out_valid.
  - Unsigned mode: co = true carry out of Y_WIDTH.
  - Signed mode: co = raw carry out of the MSB, with no overflow interpretation.
- Undefined: no co port and no carry-out register. The final slice carry is discarded.

Test Plan:
- Unsigned carry ripple across slices: A_WIDTH=8, B_WIDTH=8, Y_WIDTH=12, SLICE_WIDTH=4, a=0xFF, b=0x01 handshake at T -> out_valid first at T+4, y=0x100, co=0.
- Wrap-around: A_WIDTH=B_WIDTH=Y_WIDTH=8, SLICE_WIDTH=3, a=0xFF, b=0x02 -> NSLICE=3, y=0x01, co=1 (with ADD_SLICE_COUT_EN), out_valid at T+4.
- Signed extension: A_SIGNED=B_SIGNED=1, A_WIDTH=4, B_WIDTH=8, Y_WIDTH=8, SLICE_WIDTH=4, a=4'hF (-1), b=8'h05 -> y=8'h04. Repeat with B_SIGNED=0 -> y=8'h14.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> y, out_valid and in_ready=0 stay stable. Raising out_ready gives in_ready=1 the next cycle, and the new operands are accepted only then.
- Reset mid-run: Y_WIDTH=12, SLICE_WIDTH=4, drop reset_n in the second RUN cycle -> out_valid=0, y=0, in_ready=1 immediately. After release, the next operation a=0x10, b=0x20 yields y=0x030.
- Single-slice mode: SLICE_WIDTH=16, Y_WIDTH=9, a=0xFF, b=0xFF -> y=0x1FE, out_valid at T+2.
